// File: rtl/sram_rw_port_ctrl_if.sv
// ============================================================================
// Module   : sram_rw_port_ctrl_if
// Brief    : Write, read and read-response channels of sram_rw_port_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 2,
  parameter int LANE_W = 43
);
  localparam int DATA_W = LANES * LANE_W;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_mask;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output wr_valid, wr_addr, wr_mask, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  resp_valid, resp_data,
    output resp_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_mask, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output resp_valid, resp_data,
    input  resp_ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_rw_port_ctrl.sv
// ============================================================================
// Module   : sram_rw_port_ctrl
// Brief    : Zero-fills a single-port RW SRAM, arbitrates write/read requests
//            onto RW0 and returns read data through a 2-entry response FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_rw_port_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LANES  = 2,
  parameter int LANE_W = 43,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic               clock,
  input  logic               reset_n,
  sram_rw_port_ctrl_if.slave bus,
  output logic               init_done,
  output logic               RW0_clk,
  output logic               RW0_en,
  output logic               RW0_wmode,
  output logic [ADDR_W-1:0]  RW0_addr,
  output logic [LANES-1:0]   RW0_wmask,
  output logic [DATA_W-1:0]  RW0_wdata,
  input  logic [DATA_W-1:0]  RW0_rdata
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic              r_inflight;
  logic              r_prio;       // 0: write wins a contended cycle
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_run;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_grant_wr;
  logic              w_grant_rd;

  assign w_run   = reset_n && (r_state == ST_RUN);
  assign w_pop   = reset_n && (r_count != 2'd0) && bus.resp_ready;
  // Slots committed once this cycle settles; the in-flight read already owns one.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_wr_ok = w_run && bus.wr_valid;
  assign w_rd_ok = w_run && bus.rd_valid && (w_occ < 3'd2);

  assign w_grant_wr = w_wr_ok && (!w_rd_ok || !r_prio);
  assign w_grant_rd = w_rd_ok && (!w_wr_ok ||  r_prio);

  always_comb begin
    w_state_next = r_state;
    RW0_en       = 1'b0;
    RW0_wmode    = 1'b0;
    RW0_addr     = '0;
    RW0_wmask    = '0;
    RW0_wdata    = '0;
    bus.wr_ready = 1'b0;
    bus.rd_ready = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (reset_n) begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = r_fill_cnt;
          RW0_wmask = '1;
        end
        if (r_fill_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.wr_ready = w_grant_wr;
        bus.rd_ready = w_grant_rd;
        if (w_grant_wr) begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = bus.wr_addr;
          RW0_wmask = bus.wr_mask;
          RW0_wdata = bus.wr_data;
        end else if (w_grant_rd) begin
          RW0_en    = 1'b1;
          RW0_addr  = bus.rd_addr;
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_fill_cnt <= '0;
      r_inflight <= 1'b0;
      r_prio     <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
      end
      r_inflight <= w_grant_rd;
      if (w_wr_ok && w_rd_ok) begin
        r_prio <= ~r_prio;
      end
      if (r_inflight) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Macro read data is only valid in the cycle after the read grant.
  always_ff @(posedge clock) begin
    if (r_inflight) begin
      r_fifo[r_wptr] <= RW0_rdata;
    end
  end

  assign bus.resp_valid = reset_n && (r_count != 2'd0);
  assign bus.resp_data  = bus.resp_valid ? r_fifo[r_rptr] : '0;
  assign init_done      = w_run;
  assign RW0_clk        = clock;

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_port_ctrl.sv
// ============================================================================
// Module   : tb_sram_rw_port_ctrl
// Brief    : Directed bench for sram_rw_port_ctrl with a behavioural SRAM and
//            a cycle-level reference model checked every cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_rw_port_ctrl;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int LANES  = 2;
  localparam int LANE_W = 43;
  localparam int DATA_W = 86;
  localparam logic [DATA_W-1:0] GARB = {43'h555_5555_5555, 43'h2AA_AAAA_AAAA};

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done;
  logic              RW0_clk, RW0_en, RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [LANES-1:0]  RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata, RW0_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sram_rw_port_ctrl_if #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) bus ();

  sram_rw_port_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .init_done (init_done),
    .RW0_clk   (RW0_clk),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_addr  (RW0_addr),
    .RW0_wmask (RW0_wmask),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  // Behavioural macro: garbage on rdata except in the cycle after a read.
  logic [DATA_W-1:0] macro_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) macro_mem[i] = GARB ^ DATA_W'(i);
  always @(posedge RW0_clk) begin
    RW0_rdata <= GARB;
    if (RW0_en && RW0_wmode) begin
      for (int l = 0; l < LANES; l++)
        if (RW0_wmask[l]) macro_mem[RW0_addr][l*LANE_W +: LANE_W] <= RW0_wdata[l*LANE_W +: LANE_W];
    end else if (RW0_en) begin
      RW0_rdata <= macro_mem[RW0_addr];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int                m_cyc = 0;
  bit                m_active = 0;
  logic [DATA_W-1:0] m_q[$];
  bit                m_pend = 0;
  logic [DATA_W-1:0] m_pend_d;
  bit                m_prio = 0;
  logic [DATA_W-1:0] m_mem [DEPTH];

  initial begin : compare
    bit gw, gr, pop, wok, rok;
    int occ;
    forever begin
      @(negedge clock); #1;
      chk("rw0_clk", RW0_clk, clock);
      if (!reset_n) begin
        chk("rst_en", RW0_en, 0);        chk("rst_wmode", RW0_wmode, 0);
        chk("rst_addr", RW0_addr, 0);    chk("rst_wmask", RW0_wmask, 0);
        chk("rst_wdata", RW0_wdata, 0);  chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_init_done", init_done, 0);
        m_cyc = 0; m_q.delete(); m_pend = 0; m_prio = 0; m_active = 1;
      end else if (m_active) begin
        if (m_cyc < DEPTH) begin
          chk("init_en", RW0_en, 1);      chk("init_wmode", RW0_wmode, 1);
          chk("init_addr", RW0_addr, m_cyc); chk("init_wmask", RW0_wmask, 2'b11);
          chk("init_wdata", RW0_wdata, 0);
          chk("init_wr_ready", bus.wr_ready, 0); chk("init_rd_ready", bus.rd_ready, 0);
          chk("init_done_low", init_done, 0);
          chk("init_resp_valid", bus.resp_valid, 0);
          m_mem[m_cyc] = '0;
          m_cyc++;
        end else begin
          chk("init_done_high", init_done, 1);
          pop = (m_q.size() > 0) && bus.resp_ready;
          occ = m_q.size() + int'(m_pend) - int'(pop);
          wok = bus.wr_valid;
          rok = bus.rd_valid && (occ < 2);
          if (wok && rok) begin
            gw = !m_prio; gr = m_prio; m_prio = !m_prio;
          end else begin
            gw = wok; gr = rok;
          end
          chk("wr_ready", bus.wr_ready, gw);
          chk("rd_ready", bus.rd_ready, gr);
          chk("rw0_en", RW0_en, gw || gr);
          chk("rw0_wmode", RW0_wmode, gw);
          chk("rw0_addr", RW0_addr, gw ? bus.wr_addr : (gr ? bus.rd_addr : 8'h00));
          chk("rw0_wmask", RW0_wmask, gw ? bus.wr_mask : 2'b00);
          chk("rw0_wdata", RW0_wdata, gw ? bus.wr_data : '0);
          chk("resp_valid", bus.resp_valid, m_q.size() > 0);
          if (m_q.size() > 0) chk("resp_data", bus.resp_data, m_q[0]);
          if (pop) void'(m_q.pop_front());
          if (m_pend) m_q.push_back(m_pend_d);
          m_pend = gr;
          if (gr) m_pend_d = m_mem[bus.rd_addr];
          if (gw)
            for (int l = 0; l < LANES; l++)
              if (bus.wr_mask[l]) m_mem[bus.wr_addr][l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d);
    bit ok = 0;
    bus.wr_valid = 1; bus.wr_addr = a; bus.wr_mask = m; bus.wr_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.wr_ready) begin ok = 1; break; end
      tick();
    end
    tick();
    bus.wr_valid = 0;
    chk("wr_handshake", ok, 1);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [DATA_W-1:0] d, output int lat);
    bit ok = 0;
    bus.rd_valid = 1; bus.rd_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rd_ready) begin ok = 1; break; end
      tick();
    end
    tick();
    bus.rd_valid = 0;
    chk("rd_handshake", ok, 1);
    lat = 1; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.resp_valid) begin d = bus.resp_data; break; end
      lat++;
    end
    tick();
  endtask

  initial begin : driver
    logic [DATA_W-1:0] d, d30, d31;
    logic [7:0] g;
    int lat, n, acc, stale;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_mask = 0; bus.wr_data = 0;
    bus.rd_valid = 0; bus.rd_addr = 0; bus.resp_ready = 0;
    repeat (3) tick();
    reset_n = 1;
    n = 0;
    while (!init_done && n < 400) begin tick(); n++; end
    chk("init_cycles", n, 256);

    bus.resp_ready = 1;
    do_read(8'h7F, d, lat);
    chk("read_7f_zero", d, 86'h0);
    chk("read_7f_latency", lat, 2);

    do_write(8'h10, 2'b11, {43'h123, 43'h456});
    do_read(8'h10, d, lat);
    chk("read_10_full", d, {43'h123, 43'h456});
    chk("read_10_latency", lat, 2);

    do_write(8'h10, 2'b01, {DATA_W{1'b1}});
    do_read(8'h10, d, lat);
    chk("read_10_masked", d, {43'h123, 43'h7FF_FFFF_FFFF});

    do_write(8'h10, 2'b00, 86'h0);
    do_read(8'h10, d, lat);
    chk("read_10_nomask", d, {43'h123, 43'h7FF_FFFF_FFFF});

    // Contended requests: grants must alternate starting with the write.
    bus.wr_valid = 1; bus.wr_addr = 8'h20; bus.wr_mask = 2'b11; bus.wr_data = 86'hABC;
    bus.rd_valid = 1; bus.rd_addr = 8'h21;
    g = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      g = {g[5:0], bus.wr_ready, bus.rd_ready};
      tick();
    end
    bus.wr_valid = 0; bus.rd_valid = 0;
    chk("alternate_grants", g, 8'b10011001);
    repeat (4) tick();

    d30 = {43'h30, 43'h1_0000_0030};
    d31 = {43'h31, 43'h2_0000_0031};
    do_write(8'h30, 2'b11, d30);
    do_write(8'h31, 2'b11, d31);
    bus.resp_ready = 0; bus.rd_addr = 8'h30; bus.rd_valid = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.rd_ready) acc++;
      tick();
      if (acc >= 1) bus.rd_addr = 8'h31;
    end
    chk("bp_accepts", acc, 2);
    bus.resp_ready = 1;
    @(negedge clock);
    chk("bp_reopen", bus.rd_ready, 1);
    chk("bp_head0", bus.resp_data, d30);
    tick();
    bus.rd_valid = 0;
    @(negedge clock);
    chk("bp_head1", bus.resp_data, d31);
    tick();
    repeat (4) tick();

    // Reset with one entry queued and one read in flight.
    bus.resp_ready = 0; bus.rd_addr = 8'h30; bus.rd_valid = 1;
    acc = 0;
    for (int i = 0; i < 6 && acc < 2; i++) begin
      @(negedge clock);
      if (bus.rd_ready) acc++;
      tick();
    end
    chk("rst_pre_accepts", acc, 2);
    bus.rd_valid = 0; reset_n = 0;
    @(negedge clock);
    chk("rst_resp_gone", bus.resp_valid, 0);
    tick();
    reset_n = 1; bus.resp_ready = 1;
    n = 0; stale = 0;
    while (!init_done && n < 400) begin
      @(negedge clock);
      if (bus.resp_valid) stale++;
      tick();
      n++;
    end
    chk("reinit_cycles", n, 256);
    chk("reinit_stale_resp", stale, 0);
    do_read(8'h10, d, lat);
    chk("reinit_read_zero", d, 86'h0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
